// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header
// Strips the first N bytes (N = popcount of keep_strip) from each AXI-Stream
// packet, presents them on the header port, and re-packs the remaining bytes
// into full beats on the payload port. Byte 0 is data[DATA_WD-1 -: 8] and
// keep bit DATA_BYTE_WD-1 qualifies it.
//
// Handshakes: every channel transfers on a rising edge where valid and ready
// are both 1. A valid output holds its data stable until accepted, and valid
// never depends combinationally on the matching ready.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // header length, one handshake per packet
    input  logic                    valid_len,
    output logic                    ready_len,
    input  logic [DATA_BYTE_WD-1:0] keep_strip,
    // input packet stream
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    // payload stream with the header removed
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    // extracted header
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    // current FSM state, for observation only
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = $clog2(DATA_BYTE_WD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // High-aligned keep mask with k bytes set (k clipped to 0..DATA_BYTE_WD).
    function automatic logic [DATA_BYTE_WD-1:0] hi_mask(input int k);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i >= DATA_BYTE_WD - k) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Expand a keep mask into a per-bit data mask.
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    function automatic int popcount(input logic [DATA_BYTE_WD-1:0] k);
        int c;
        c = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + int'(k[i]);
        end
        return c;
    endfunction

    // Move data k bytes toward the top (earlier on the wire).
    function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] d, input int k);
        return d << (8 * k);
    endfunction

    // Move data k bytes toward the bottom (later on the wire).
    function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] d, input int k);
        return d >> (8 * k);
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        n_q, n_d;       // header byte count of the packet
    logic [CNT_W-1:0]        r_q, r_d;       // residual byte count
    logic [DATA_WD-1:0]      res_q, res_d;   // residual bytes, top-aligned
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    logic                    ready_len_c;
    logic                    ready_in_c;
    logic                    out_free;
    logic                    strip_ok;
    logic [CNT_W-1:0]        strip_n;
    logic [DATA_WD-1:0]      din_m;
    int                      beat_b;
    int                      hdr_b;
    int                      total_b;

    // Header length decode: a mask that is not low-aligned contiguous means no header.
    always_comb begin
        strip_ok = ((keep_strip & (keep_strip + DATA_BYTE_WD'(1))) == '0);
        strip_n  = strip_ok ? CNT_W'(popcount(keep_strip)) : '0;
    end

    // Next-state, residual and output-slot logic.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        r_d         = r_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        hdr_valid_d = hdr_valid_q;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        ready_len_c = 1'b0;
        ready_in_c  = 1'b0;
        hdr_b       = 0;
        total_b     = 0;

        // The payload slot can take a new beat when empty or being drained now.
        out_free = !out_valid_q || ready_out;
        beat_b   = popcount(keep_in);
        din_m    = data_in & byte_mask(keep_in);

        if (out_valid_q && ready_out) out_valid_d = 1'b0;
        if (hdr_valid_q && ready_header) hdr_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A new header may only start once the previous one is taken.
                ready_len_c = !hdr_valid_q;
                if (valid_len && ready_len_c) begin
                    n_d     = strip_n;
                    r_d     = CNT_W'(DATA_BYTE_WD) - strip_n;
                    res_d   = '0;
                    state_d = HDR;
                end
            end

            HDR: begin
                // Gated on the payload slot: a short last beat may emit payload
                // while the previous packet's final beat is still waiting.
                ready_in_c = out_free;
                if (valid_in && ready_in_c) begin
                    if (last_in) begin
                        hdr_b       = (int'(n_q) < beat_b) ? int'(n_q) : beat_b;
                        hdr_data_d  = din_m & byte_mask(hi_mask(hdr_b));
                        hdr_keep_d  = hi_mask(hdr_b);
                        hdr_valid_d = (hdr_b != 0);
                        if (beat_b > int'(n_q)) begin
                            out_valid_d = 1'b1;
                            out_data_d  = shl_bytes(din_m, int'(n_q));
                            out_keep_d  = hi_mask(beat_b - int'(n_q));
                            out_last_d  = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        hdr_data_d  = data_in & byte_mask(hi_mask(int'(n_q)));
                        hdr_keep_d  = hi_mask(int'(n_q));
                        hdr_valid_d = (n_q != '0);
                        res_d       = shl_bytes(data_in, int'(n_q));
                        state_d     = BODY;
                    end
                end
            end

            BODY: begin
                ready_in_c = out_free;
                if (valid_in && ready_in_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q | shr_bytes(din_m, int'(r_q));
                    total_b     = int'(r_q) + beat_b;
                    if (!last_in) begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        res_d      = shl_bytes(din_m, int'(n_q));
                    end else if (total_b <= DATA_BYTE_WD) begin
                        out_keep_d = hi_mask(total_b);
                        out_last_d = 1'b1;
                        res_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        res_d      = shl_bytes(din_m, int'(n_q));
                        r_d        = CNT_W'(total_b - DATA_BYTE_WD);
                        state_d    = FLUSH;
                    end
                end
            end

            FLUSH: begin
                // Leftover bytes of the last beat go out once the slot frees.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q;
                    out_keep_d  = hi_mask(int'(r_q));
                    out_last_d  = 1'b1;
                    res_d       = '0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            r_q         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            r_q         <= r_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    // Ready outputs are forced low while reset is asserted.
    always_comb begin
        ready_len    = rst_n & ready_len_c;
        ready_in     = rst_n & ready_in_c;
        valid_out    = out_valid_q;
        data_out     = out_data_q;
        keep_out     = out_keep_q;
        last_out     = out_last_q;
        valid_header = hdr_valid_q;
        header_out   = hdr_data_q;
        keep_header  = hdr_keep_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Testbench for axi_stream_extract_header: directed packets, a mid-packet
// reset, then 100 random packets under random backpressure. Expected beats
// come from a byte-level model: drop the first N bytes, repack the rest.
module tb_axi_stream_extract_header;

    localparam int W  = 32;
    localparam int BW = 4;
    localparam int EW = 1 + BW + W;   // {last, keep, data}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_len = 1'b0;
    logic          ready_len;
    logic [BW-1:0] keep_strip = '0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [BW-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [W-1:0]  data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out = 1'b0;
    logic          valid_header;
    logic [W-1:0]  header_out;
    logic [BW-1:0] keep_header;
    logic          ready_header = 1'b0;
    logic [1:0]    dbg_state;

    logic [EW-1:0]     exp_q[$];
    logic [BW+W-1:0]   hdr_q[$];
    logic [7:0]        pkt_q[$];

    int checks = 0;
    int errors = 0;
    bit hold_ready = 1'b1;

    axi_stream_extract_header #(.DATA_WD(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_len(valid_len), .ready_len(ready_len), .keep_strip(keep_strip),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out), .ready_out(ready_out),
        .valid_header(valid_header), .header_out(header_out),
        .keep_header(keep_header), .ready_header(ready_header),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Build a top-aligned word and keep from pkt_q[s .. s+cnt-1].
    task automatic pack(input int s, input int cnt, output logic [W-1:0] d, output logic [BW-1:0] k);
        d = '0;
        k = '0;
        for (int j = 0; j < cnt; j++) begin
            d[W-1-8*j -: 8] = pkt_q[s+j];
            k[BW-1-j] = 1'b1;
        end
    endtask

    // Reference model: header = first min(N,L) bytes, payload = the rest repacked.
    task automatic model_push(input logic [BW-1:0] strip);
        int n, len, h, cnt;
        logic [W-1:0]  d;
        logic [BW-1:0] k;
        case (strip)
            4'b0000: n = 0;
            4'b0001: n = 1;
            4'b0011: n = 2;
            4'b0111: n = 3;
            4'b1111: n = 4;
            default: n = 0;
        endcase
        len = pkt_q.size();
        h = (n < len) ? n : len;
        if (h > 0) begin
            pack(0, h, d, k);
            hdr_q.push_back({k, d});
        end
        for (int s = h; s < len; s += BW) begin
            cnt = (len - s < BW) ? len - s : BW;
            pack(s, cnt, d, k);
            exp_q.push_back({(s + BW >= len), k, d});
        end
    endtask

    // Wait (bounded) until the selected ready is high, then let the edge pass.
    task automatic wait_ready(input bit which_in);
        int t;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (which_in ? ready_in : ready_len) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL timeout_%s got=0 exp=1", which_in ? "ready_in" : "ready_len");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one packet from pkt_q; unused bytes of a partial beat carry garbage.
    task automatic drive_packet(input logic [BW-1:0] strip, input bit gaps);
        int len, cnt;
        logic [W-1:0]  d;
        logic [BW-1:0] k;
        len = pkt_q.size();
        valid_len  = 1'b1;
        keep_strip = strip;
        wait_ready(1'b0);
        valid_len  = 1'b0;
        keep_strip = BW'($urandom);
        for (int s = 0; s < len; s += BW) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            cnt = (len - s < BW) ? len - s : BW;
            pack(s, cnt, d, k);
            for (int j = cnt; j < BW; j++) d[W-1-8*j -: 8] = 8'($urandom);
            valid_in = 1'b1;
            data_in  = d;
            keep_in  = k;
            last_in  = (s + BW >= len);
            wait_ready(1'b1);
            valid_in = 1'b0;
            last_in  = 1'b0;
            data_in  = $urandom;
        end
    endtask

    task automatic load_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input int len);
        logic [3*W-1:0] all;
        all = {w0, w1, w2};
        pkt_q.delete();
        for (int i = 0; i < len; i++) pkt_q.push_back(all[3*W-1-8*i -: 8]);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("queues_drained", 64'(exp_q.size() + hdr_q.size()), 64'd0);
    endtask

    // ---------------- backpressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) begin
                ready_out    = 1'b0;
                ready_header = 1'b0;
            end else begin
                ready_out    = ($urandom_range(0, 3) != 0);
                ready_header = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected got=%h exp=none", {last_out, keep_out, data_out});
                end else begin
                    check("out_beat", 64'({last_out, keep_out, data_out}), 64'(exp_q.pop_front()));
                end
            end
            if (valid_header && ready_header) begin
                if (hdr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hdr_unexpected got=%h exp=none", {keep_header, header_out});
                end else begin
                    check("header", 64'({keep_header, header_out}), 64'(hdr_q.pop_front()));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [BW-1:0] strip;
        int len;

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_len", 64'(ready_len), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_valid_header", 64'(valid_header), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_len", 64'(ready_len), 64'd1);
        @(posedge clk);
        #1;
        hold_ready = 1'b0;

        // N=2 two full beats
        hdr_q.push_back({4'b1100, 32'hAABB0000});
        exp_q.push_back({1'b0, 4'b1111, 32'hCCDD1122});
        exp_q.push_back({1'b1, 4'b1100, 32'h33440000});
        load_words(32'hAABBCCDD, 32'h11223344, 32'h0, 8);
        drive_packet(4'b0011, 1'b0);

        // N=1, full beat then one-byte last beat
        hdr_q.push_back({4'b1000, 32'h01000000});
        exp_q.push_back({1'b1, 4'b1111, 32'h02030405});
        load_words(32'h01020304, 32'h05060708, 32'h0, 5);
        drive_packet(4'b0001, 1'b0);

        // N=4, three full beats
        hdr_q.push_back({4'b1111, 32'hDEADBEEF});
        exp_q.push_back({1'b0, 4'b1111, 32'h12345678});
        exp_q.push_back({1'b1, 4'b1111, 32'h9ABCDEF0});
        load_words(32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 12);
        drive_packet(4'b1111, 1'b0);

        // N=3, single 3-byte last beat: header only
        hdr_q.push_back({4'b1110, 32'hA1A2A300});
        load_words(32'hA1A2A3A4, 32'h0, 32'h0, 3);
        drive_packet(4'b0111, 1'b0);

        // non-contiguous strip: whole packet passes through, no header
        exp_q.push_back({1'b0, 4'b1111, 32'h55667788});
        exp_q.push_back({1'b1, 4'b1100, 32'h99AA0000});
        load_words(32'h55667788, 32'h99AABBCC, 32'h0, 6);
        drive_packet(4'b0101, 1'b0);
        drain();

        // reset in the middle of BODY with outputs held
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        load_words(32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 12);
        pkt_q = pkt_q[0:7];
        valid_len  = 1'b1;
        keep_strip = 4'b0011;
        wait_ready(1'b0);
        valid_len = 1'b0;
        for (int s = 0; s < 8; s += 4) begin
            valid_in = 1'b1;
            data_in  = {pkt_q[s], pkt_q[s+1], pkt_q[s+2], pkt_q[s+3]};
            keep_in  = 4'b1111;
            last_in  = 1'b0;
            wait_ready(1'b1);
        end
        valid_in = 1'b0;
        check("mid_body_state", 64'(dbg_state), 64'd2);
        check("mid_body_valid_out", 64'(valid_out), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_valid_out", 64'(valid_out), 64'd0);
        check("mrst_valid_header", 64'(valid_header), 64'd0);
        check("mrst_data_out", 64'(data_out), 64'd0);
        check("mrst_keep_out", 64'(keep_out), 64'd0);
        check("mrst_last_out", 64'(last_out), 64'd0);
        check("mrst_header_out", 64'(header_out), 64'd0);
        check("mrst_keep_header", 64'(keep_header), 64'd0);
        check("mrst_ready_in", 64'(ready_in), 64'd0);
        check("mrst_ready_len", 64'(ready_len), 64'd0);
        check("mrst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mrst_release_ready_len", 64'(ready_len), 64'd1);
        @(posedge clk);
        #1;
        hold_ready = 1'b0;

        // random packets with random header length and backpressure
        for (int p = 0; p < 100; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                strip = BW'($urandom);
            end else begin
                case ($urandom_range(0, 4))
                    0: strip = 4'b0000;
                    1: strip = 4'b0001;
                    2: strip = 4'b0011;
                    3: strip = 4'b0111;
                    default: strip = 4'b1111;
                endcase
            end
            len = $urandom_range(1, 13);
            pkt_q.delete();
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
            model_push(strip);
            drive_packet(strip, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
